// File: rtl/cnn_layer_accel_result_packer.sv
// Packs the quad's result stream into C_LANES-wide words, tracks output coordinates and marks
// the final word of a job. A 2-entry FIFO decouples packing from downstream backpressure.
module cnn_layer_accel_result_packer #(
  parameter int unsigned C_LANES        = 8,
  parameter int unsigned C_RESULT_WIDTH = 16,
  parameter int unsigned C_DIM_WIDTH    = 10
) (
  input  logic                              i_clk_if,
  input  logic                              i_rst,
  input  logic                              i_cfg_valid,
  output logic                              o_cfg_ready,
  input  logic [C_DIM_WIDTH-1:0]            i_cfg_num_rows,
  input  logic [C_DIM_WIDTH-1:0]            i_cfg_num_cols,
  input  logic [C_DIM_WIDTH-1:0]            i_cfg_num_kernels,
  output logic                              o_cfg_err,
  input  logic                              i_result_valid,
  output logic                              o_result_accept,
  input  logic [C_RESULT_WIDTH-1:0]         i_result_data,
  output logic                              o_pack_valid,
  input  logic                              i_pack_ready,
  output logic [C_LANES*C_RESULT_WIDTH-1:0] o_pack_data,
  output logic [C_LANES-1:0]                o_pack_lane_mask,
  output logic                              o_pack_last,
  output logic [C_DIM_WIDTH-1:0]            o_output_row,
  output logic [C_DIM_WIDTH-1:0]            o_output_col,
  output logic [C_DIM_WIDTH-1:0]            o_output_depth,
  output logic                              o_job_done
);

  localparam int unsigned LaneW = (C_LANES > 1) ? $clog2(C_LANES) : 1;
  localparam int unsigned WordW = C_LANES * C_RESULT_WIDTH;

  typedef enum logic [1:0] {StIdle, StPack, StDrain} state_e;

  state_e                 r_state;
  logic [C_DIM_WIDTH-1:0] r_num_rows, r_num_cols, r_num_kernels;
  logic [C_DIM_WIDTH-1:0] r_row, r_col, r_depth;
  logic [LaneW-1:0]       r_lane_idx;
  logic [WordW-1:0]       r_pack_data;
  logic [WordW-1:0]       r_fifo_data [2];
  logic [C_LANES-1:0]     r_fifo_mask [2];
  logic [1:0]             r_fifo_last;
  logic                   r_wr_ptr, r_rd_ptr;
  logic [1:0]             r_fifo_count;
  logic                   r_cfg_err, r_job_done;

  logic               w_accept, w_fire, w_push, w_pop, w_final, w_lane_full, w_cfg_zero;
  logic               w_depth_wrap, w_col_wrap, w_row_wrap;
  logic [WordW-1:0]   w_word;
  logic [C_LANES-1:0] w_mask;

  assign w_accept     = (r_state == StPack) && (r_fifo_count < 2'd2);
  assign w_fire       = w_accept && i_result_valid;
  assign w_depth_wrap = (r_depth == r_num_kernels - C_DIM_WIDTH'(1));
  assign w_col_wrap   = (r_col == r_num_cols - C_DIM_WIDTH'(1));
  assign w_row_wrap   = (r_row == r_num_rows - C_DIM_WIDTH'(1));
  assign w_final      = w_depth_wrap && w_col_wrap && w_row_wrap;
  assign w_lane_full  = (r_lane_idx == LaneW'(C_LANES - 1));
  assign w_push       = w_fire && (w_lane_full || w_final);
  assign w_pop        = (r_fifo_count != 2'd0) && i_pack_ready;
  assign w_cfg_zero   = (i_cfg_num_rows == '0) || (i_cfg_num_cols == '0) ||
                        (i_cfg_num_kernels == '0);

  // Word as it would look with the incoming result merged into the current lane.
  always_comb begin
    w_word = r_pack_data;
    w_mask = '0;
    for (int i = 0; i < int'(C_LANES); i++) begin
      if (r_lane_idx == LaneW'(i)) w_word[i*C_RESULT_WIDTH +: C_RESULT_WIDTH] = i_result_data;
      w_mask[i] = (LaneW'(i) <= r_lane_idx);
    end
  end

  always_ff @(posedge i_clk_if) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_num_rows     <= '0;
      r_num_cols     <= '0;
      r_num_kernels  <= '0;
      r_row          <= '0;
      r_col          <= '0;
      r_depth        <= '0;
      r_lane_idx     <= '0;
      r_pack_data    <= '0;
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_mask[0] <= '0;
      r_fifo_mask[1] <= '0;
      r_fifo_last    <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_fifo_count   <= 2'd0;
      r_cfg_err      <= 1'b0;
      r_job_done     <= 1'b0;
    end else begin
      r_cfg_err  <= 1'b0;
      r_job_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_cfg_valid) begin
            if (w_cfg_zero) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_num_rows    <= i_cfg_num_rows;
              r_num_cols    <= i_cfg_num_cols;
              r_num_kernels <= i_cfg_num_kernels;
              r_row         <= '0;
              r_col         <= '0;
              r_depth       <= '0;
              r_lane_idx    <= '0;
              r_pack_data   <= '0;
              r_state       <= StPack;
            end
          end
        end
        StPack: begin
          if (w_fire) begin
            // Depth runs fastest, carrying into col, then row.
            if (w_depth_wrap) begin
              r_depth <= '0;
              if (w_col_wrap) begin
                r_col <= '0;
                r_row <= w_row_wrap ? '0 : r_row + C_DIM_WIDTH'(1);
              end else begin
                r_col <= r_col + C_DIM_WIDTH'(1);
              end
            end else begin
              r_depth <= r_depth + C_DIM_WIDTH'(1);
            end
            if (w_push) begin
              r_lane_idx  <= '0;
              r_pack_data <= '0;
            end else begin
              r_lane_idx  <= r_lane_idx + LaneW'(1);
              r_pack_data <= w_word;
            end
            if (w_final) r_state <= StDrain;
          end
        end
        StDrain: begin
          if (w_pop && r_fifo_last[r_rd_ptr]) begin
            r_job_done <= 1'b1;
            r_state    <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase

      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_word;
        r_fifo_mask[r_wr_ptr] <= w_mask;
        r_fifo_last[r_wr_ptr] <= w_final;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + 2'd1;
        2'b01:   r_fifo_count <= r_fifo_count - 2'd1;
        default: r_fifo_count <= r_fifo_count;
      endcase
    end
  end

  assign o_cfg_ready      = (r_state == StIdle);
  assign o_cfg_err        = r_cfg_err;
  assign o_result_accept  = w_accept;
  assign o_pack_valid     = (r_fifo_count != 2'd0);
  // Head is gated so stale entries never show on the bus while empty.
  assign o_pack_data      = o_pack_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign o_pack_lane_mask = o_pack_valid ? r_fifo_mask[r_rd_ptr] : '0;
  assign o_pack_last      = o_pack_valid && r_fifo_last[r_rd_ptr];
  assign o_output_row     = r_row;
  assign o_output_col     = r_col;
  assign o_output_depth   = r_depth;
  assign o_job_done       = r_job_done;

endmodule

// File: tb/tb_cnn_layer_accel_result_packer.sv
// Directed bench for the result packer: full and partial words, backpressure, rejected
// configuration, coordinate tracking and reset in the middle of a job.
module tb_cnn_layer_accel_result_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid, cfg_ready, cfg_err;
  logic [9:0]   cfg_rows, cfg_cols, cfg_kernels;
  logic         result_valid, result_accept;
  logic [15:0]  result_data;
  logic         pack_valid, pack_ready, pack_last;
  logic [127:0] pack_data;
  logic [7:0]   pack_mask;
  logic [9:0]   out_row, out_col, out_depth;
  logic         job_done;

  int checks = 0;
  int failures = 0;

  logic [15:0]  tb_data [0:127];
  logic [127:0] got_data [$];
  logic [7:0]   got_mask [$];
  logic         got_last [$];
  logic [9:0]   g_row [0:127];
  logic [9:0]   g_col [0:127];
  logic [9:0]   g_dep [0:127];
  int           g_done_cyc, g_last_pop_cyc, g_send_cyc, g_sent_at_hold;
  logic         g_accept_at_hold;
  bit           g_timeout;

  always #5 clk = ~clk;

  cnn_layer_accel_result_packer dut (
    .i_clk_if          (clk),
    .i_rst             (rst),
    .i_cfg_valid       (cfg_valid),
    .o_cfg_ready       (cfg_ready),
    .i_cfg_num_rows    (cfg_rows),
    .i_cfg_num_cols    (cfg_cols),
    .i_cfg_num_kernels (cfg_kernels),
    .o_cfg_err         (cfg_err),
    .i_result_valid    (result_valid),
    .o_result_accept   (result_accept),
    .i_result_data     (result_data),
    .o_pack_valid      (pack_valid),
    .i_pack_ready      (pack_ready),
    .o_pack_data       (pack_data),
    .o_pack_lane_mask  (pack_mask),
    .o_pack_last       (pack_last),
    .o_output_row      (out_row),
    .o_output_col      (out_col),
    .o_output_depth    (out_depth),
    .o_job_done        (job_done)
  );

  // Expected word: nl lanes from tb_data starting at base, remaining lanes zero.
  function automatic logic [127:0] exp_word(input int base, input int nl);
    logic [127:0] w;
    w = '0;
    for (int l = 0; l < nl; l++) w[l*16 +: 16] = tb_data[base + l];
    return w;
  endfunction

  task automatic apply_cfg(input logic [9:0] r, input logic [9:0] c, input logic [9:0] k);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_rows = r; cfg_cols = c; cfg_kernels = k;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Drives n results, holds pack_ready low for the first 'hold' cycles and records popped words.
  task automatic stream(input int n, input int hold);
    int  sent = 0;
    int  cyc = 0;
    bit  done = 0;
    got_data.delete(); got_mask.delete(); got_last.delete();
    g_done_cyc = -1; g_last_pop_cyc = -1; g_send_cyc = -1; g_sent_at_hold = -1;
    g_accept_at_hold = 1'bx; g_timeout = 0;
    while (!done && cyc < 2000) begin
      pack_ready   = (cyc >= hold);
      result_valid = (sent < n);
      result_data  = tb_data[sent < 128 ? sent : 0];
      #1;
      if (cyc == hold) begin
        g_sent_at_hold   = sent;
        g_accept_at_hold = result_accept;
      end
      if (sent < 128) begin
        g_row[sent] = out_row; g_col[sent] = out_col; g_dep[sent] = out_depth;
      end
      if (job_done) begin
        done = 1; g_done_cyc = cyc;
      end
      if (pack_valid && pack_ready) begin
        got_data.push_back(pack_data); got_mask.push_back(pack_mask);
        got_last.push_back(pack_last); g_last_pop_cyc = cyc;
      end
      if (result_valid && result_accept) begin
        sent++;
        if (sent == n) g_send_cyc = cyc + 1;
      end
      cyc++;
      @(negedge clk);
    end
    result_valid = 1'b0;
    pack_ready   = 1'b0;
    if (!done) g_timeout = 1;
  endtask

  task automatic test_reset;
    rst = 1'b1; cfg_valid = 0; cfg_rows = 0; cfg_cols = 0; cfg_kernels = 0;
    result_valid = 0; result_data = 0; pack_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1 || cfg_err !== 1'b0 || result_accept !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%b err=%b accept=%b required 1 0 0",
               cfg_ready, cfg_err, result_accept);
    end
    checks++;
    if (pack_valid !== 1'b0 || pack_data !== '0 || pack_mask !== 8'h00 || pack_last !== 1'b0
        || job_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_pack: valid=%b data=%h mask=%h last=%b done=%b required all zero",
               pack_valid, pack_data, pack_mask, pack_last, job_done);
    end
    checks++;
    if (out_row !== 10'd0 || out_col !== 10'd0 || out_depth !== 10'd0) begin
      failures++;
      $display("FAIL reset_coord: row=%0d col=%0d depth=%0d required 0 0 0",
               out_row, out_col, out_depth);
    end
  endtask

  task automatic test_full_words;
    for (int i = 0; i < 16; i++) tb_data[i] = 16'(i + 1);
    apply_cfg(10'd2, 10'd2, 10'd4);
    stream(16, 0);
    checks++;
    if (g_timeout) begin
      failures++; $display("FAIL full_timeout: job_done not seen, required within budget");
    end
    checks++;
    if (got_data.size() != 2) begin
      failures++; $display("FAIL full_count: words=%0d required 2", got_data.size());
    end
    for (int w = 0; w < 2 && w < got_data.size(); w++) begin
      checks++;
      if (got_data[w] !== exp_word(w*8, 8) || got_mask[w] !== 8'hFF
          || got_last[w] !== (w == 1)) begin
        failures++;
        $display("FAIL full_word%0d: data=%h mask=%h last=%b required %h ff %b",
                 w, got_data[w], got_mask[w], got_last[w], exp_word(w*8, 8), (w == 1));
      end
    end
    checks++;
    if (g_send_cyc != 16) begin
      failures++; $display("FAIL full_throughput: cycles=%0d required 16", g_send_cyc);
    end
    checks++;
    if (g_done_cyc != g_last_pop_cyc + 1) begin
      failures++;
      $display("FAIL full_done_timing: done_cyc=%0d required %0d", g_done_cyc, g_last_pop_cyc + 1);
    end
    checks++;
    if (job_done !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_after: done=%b ready=%b required 0 1", job_done, cfg_ready);
    end
  endtask

  task automatic test_partial_word;
    tb_data[0] = 16'h000A; tb_data[1] = 16'h000B; tb_data[2] = 16'h000C;
    apply_cfg(10'd1, 10'd3, 10'd1);
    stream(3, 0);
    checks++;
    if (g_timeout || got_data.size() != 1) begin
      failures++;
      $display("FAIL partial_count: timeout=%0d words=%0d required 0 1", g_timeout, got_data.size());
    end
    if (got_data.size() > 0) begin
      checks++;
      if (got_data[0] !== 128'h0000_0000_0000_0000_0000_000C_000B_000A || got_mask[0] !== 8'h07
          || got_last[0] !== 1'b1) begin
        failures++;
        $display("FAIL partial_word: data=%h mask=%h last=%b required c000b000a 07 1",
                 got_data[0], got_mask[0], got_last[0]);
      end
    end
  endtask

  task automatic test_backpressure;
    int bad;
    for (int i = 0; i < 72; i++) tb_data[i] = 16'(16'h1000 + i);
    apply_cfg(10'd3, 10'd3, 10'd8);
    stream(72, 40);
    checks++;
    if (g_sent_at_hold != 16 || g_accept_at_hold !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall: accepted=%0d accept=%b required 16 0",
               g_sent_at_hold, g_accept_at_hold);
    end
    checks++;
    if (g_timeout || got_data.size() != 9) begin
      failures++;
      $display("FAIL bp_count: timeout=%0d words=%0d required 0 9", g_timeout, got_data.size());
    end
    bad = 0;
    for (int w = 0; w < got_data.size(); w++) begin
      if (got_data[w] !== exp_word(w*8, 8) || got_mask[w] !== 8'hFF || got_last[w] !== (w == 8))
      begin
        bad++;
        $display("FAIL bp_word%0d: data=%h mask=%h last=%b required %h ff %b",
                 w, got_data[w], got_mask[w], got_last[w], exp_word(w*8, 8), (w == 8));
      end
    end
    checks++;
    if (bad != 0) failures++;
  endtask

  task automatic test_rejected_cfg;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_rows = 10'd2; cfg_cols = 10'd0; cfg_kernels = 10'd2;
    @(negedge clk);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1 || result_accept !== 1'b0) begin
      failures++;
      $display("FAIL reject_pulse: err=%b ready=%b accept=%b required 1 1 0",
               cfg_err, cfg_ready, result_accept);
    end
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0 || cfg_ready !== 1'b1 || result_accept !== 1'b0) begin
      failures++;
      $display("FAIL reject_after: err=%b ready=%b accept=%b required 0 1 0",
               cfg_err, cfg_ready, result_accept);
    end
  endtask

  task automatic test_coordinates;
    for (int i = 0; i < 12; i++) tb_data[i] = 16'(16'h0200 + i);
    apply_cfg(10'd2, 10'd3, 10'd2);
    stream(12, 0);
    checks++;
    if (g_row[3] !== 10'd0 || g_col[3] !== 10'd1 || g_dep[3] !== 10'd1) begin
      failures++;
      $display("FAIL coord_idx3: row=%0d col=%0d depth=%0d required 0 1 1",
               g_row[3], g_col[3], g_dep[3]);
    end
    checks++;
    if (g_row[6] !== 10'd1 || g_col[6] !== 10'd0 || g_dep[6] !== 10'd0) begin
      failures++;
      $display("FAIL coord_idx6: row=%0d col=%0d depth=%0d required 1 0 0",
               g_row[6], g_col[6], g_dep[6]);
    end
    checks++;
    if (g_row[11] !== 10'd1 || g_col[11] !== 10'd2 || g_dep[11] !== 10'd1) begin
      failures++;
      $display("FAIL coord_idx11: row=%0d col=%0d depth=%0d required 1 2 1",
               g_row[11], g_col[11], g_dep[11]);
    end
    checks++;
    if (g_timeout || got_data.size() != 2 || got_mask[got_data.size() - 1] !== 8'h0F) begin
      failures++;
      $display("FAIL coord_words: timeout=%0d words=%0d required 0 2 with last mask 0f",
               g_timeout, got_data.size());
    end
  endtask

  task automatic test_reset_mid_job;
    for (int i = 0; i < 16; i++) tb_data[i] = 16'(16'h0300 + i);
    apply_cfg(10'd2, 10'd2, 10'd4);
    pack_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      result_valid = 1'b1; result_data = tb_data[i];
      @(negedge clk);
    end
    result_valid = 1'b0;
    checks++;
    if (out_depth !== 10'd1 || out_col !== 10'd1) begin
      failures++;
      $display("FAIL midjob_progress: col=%0d depth=%0d required 1 1", out_col, out_depth);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (cfg_ready !== 1'b1 || cfg_err !== 1'b0 || result_accept !== 1'b0 || pack_valid !== 1'b0
        || pack_data !== '0 || pack_mask !== 8'h00 || pack_last !== 1'b0 || job_done !== 1'b0
        || out_row !== 10'd0 || out_col !== 10'd0 || out_depth !== 10'd0) begin
      failures++;
      $display("FAIL midjob_reset: ready=%b acc=%b valid=%b mask=%h row=%0d col=%0d dep=%0d",
               cfg_ready, result_accept, pack_valid, pack_mask, out_row, out_col, out_depth);
    end
    for (int i = 0; i < 8; i++) tb_data[i] = 16'(16'h0050 + i);
    apply_cfg(10'd1, 10'd1, 10'd8);
    stream(8, 0);
    checks++;
    if (g_timeout || got_data.size() != 1) begin
      failures++;
      $display("FAIL midjob_count: timeout=%0d words=%0d required 0 1", g_timeout, got_data.size());
    end
    if (got_data.size() > 0) begin
      checks++;
      if (got_data[0] !== exp_word(0, 8) || got_mask[0] !== 8'hFF || got_last[0] !== 1'b1) begin
        failures++;
        $display("FAIL midjob_word: data=%h mask=%h last=%b required %h ff 1",
                 got_data[0], got_mask[0], got_last[0], exp_word(0, 8));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial_word();
    test_backpressure();
    test_rejected_cfg();
    test_coordinates();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnn_layer_accel_result_packer.md
# cnn_layer_accel_result_packer

Downstream stage of `cnn_layer_accel_quad`. It consumes the quad's 16-bit convolution result stream over the `result_valid`/`result_accept` handshake and packs eight results into 128-bit words for the output/memory path. It tracks the output coordinate (row, col, depth) of every result and marks the last word of a job. On job completion it signals the job sequencer.

## Interface
Parameters:
- `C_LANES`, 8: results per packed word.
- `C_RESULT_WIDTH`, 16: width of one result.
- `C_DIM_WIDTH`, 10: width of the row, col and kernel-count fields.

Ports:
- `clk_if`  in  1  single clock for the block (interface domain).
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  job configuration valid.
- `cfg_ready`  out  1  block idle; configuration can be taken.
- `cfg_num_rows`  in  C_DIM_WIDTH  output rows of the job.
- `cfg_num_cols`  in  C_DIM_WIDTH  output columns of the job.
- `cfg_num_kernels`  in  C_DIM_WIDTH  output depth (number of kernels).
- `cfg_err`  out  1  one-cycle pulse when a configuration is rejected.
- `result_valid`  in  1  result from the quad is valid.
- `result_accept`  out  1  result is taken on a cycle where `result_valid` and `result_accept` are both high.
- `result_data`  in  C_RESULT_WIDTH  result value.
- `pack_valid`  out  1  a packed word is available.
- `pack_ready`  in  1  downstream takes the word.
- `pack_data`  out  C_LANES*C_RESULT_WIDTH  lane i occupies bits [16i+15:16i].
- `pack_lane_mask`  out  C_LANES  valid lanes in the word.
- `pack_last`  out  1  last word of the job.
- `output_row`, `output_col`, `output_depth`  out  C_DIM_WIDTH each  coordinate of the next result to be accepted.
- `job_done`  out  1  one-cycle completion pulse.

## Operation
- Result order is depth fastest, then col, then row. Total results per job = rows × cols × kernels.
- **IDLE**
  - `cfg_ready`=1.
  - If `cfg_valid` arrives with any dimension equal to 0: pulse `cfg_err` and remain in IDLE.
  - Otherwise: latch the three dimensions, clear the counters and the lane index, and go to PACK.
- **PACK**
  - `result_accept` = (`fifo_count` < 2). This uses the registered count, so it is independent of the current lane.
  - Each accepted result is written to lane `lane_idx`. `lane_idx` then increments. The depth counter increments and wraps at kernels, carrying into col; col wraps at cols, carrying into row.
  - When lane 7 is written, or the job's final result is written, the word is pushed into the 2-entry output FIFO on the same edge:
    - the word is formed from the pack register plus the incoming data;
    - the mask has ones for the written lanes;
    - unwritten lanes are zero;
    - `pack_last` is set only on the final word.
  - After each push, `lane_idx` resets to 0 and the pack register clears.
  - After the final result is accepted, go to DRAIN.
- **DRAIN**
  - `result_accept`=0.
  - When the word with `pack_last` completes its handshake: pulse `job_done` on the next cycle and return to IDLE.
- **Output FIFO**
  - 2 entries, in-order.
  - `pack_valid` = FIFO not empty; the head entry drives `pack_data`, `pack_lane_mask` and `pack_last`.
  - A push and a pop in the same cycle are legal and leave the count unchanged.
- Coordinate counters hold their values in DRAIN and IDLE, and are cleared on acceptance of a new configuration.

## Timing
- Reset values:
  - `cfg_ready`=1.
  - `cfg_err`=0, `result_accept`=0, `pack_valid`=0, `job_done`=0.
  - `pack_data`=0, `pack_lane_mask`=0, `pack_last`=0.
  - All coordinates 0.
  - FIFO empty, state IDLE.
- Latency:
  - A configuration accepted at edge N makes `result_accept` high from cycle N+1.
  - A word completed at edge N has `pack_valid` high in cycle N+1.
- With `pack_ready` held high, throughput is 1 result per cycle with no bubbles.
- With `pack_ready` low, accepts continue until 2 words are buffered. `result_accept` then falls in the cycle after the second push. The partially filled pack register is kept.
- `cfg_valid` is ignored outside IDLE.
- `result_valid` is ignored outside PACK, and `result_data` is not sampled there.
- Reset mid-job: on the next edge all state returns to its reset values. The partial word and FIFO contents are discarded, and `job_done` is not emitted.
- Counter widths match `C_DIM_WIDTH`. There is no overflow, because each counter wraps at its configured bound.

## Test plan
- **Full words, no backpressure.** Config 2×2×4 (16 results), `result_data`=1..16, `pack_ready`=1.
  - Word0 = lanes 1..8, mask 0xFF, last 0.
  - Word1 = lanes 9..16, mask 0xFF, last 1.
  - `job_done` one cycle after the word1 handshake.
- **Partial final word.** Config 1×3×1, data 0xA,0xB,0xC.
  - One word, lanes0-2 = A,B,C, lanes3-7 = 0, mask 0x07, last 1.
- **Backpressure.** Config 3×3×8 (72 results), `pack_ready`=0 for 40 cycles, `result_valid` always 1.
  - Exactly 16 results accepted, then `result_accept`=0.
  - After release: 9 words in order, values intact, last on word 9.
- **Rejected config.** Config with `cfg_num_cols`=0.
  - `cfg_err` high for 1 cycle, `cfg_ready` stays 1, `result_accept` stays 0.
- **Coordinate tracking.** Config 2×3×2, 12 results.
  - Before result index 6 is accepted: row=1, col=0, depth=0.
  - Before index 11: row=1, col=2, depth=1.
- **Reset mid-job.** Assert `rst` after 5 of 16 results.
  - Next cycle: all outputs at reset values, no `pack_valid`.
  - A subsequent 1×1×8 job produces a single word with mask 0xFF and last 1.
